// File: rtl/komut_yukleyici.sv
// komut_yukleyici: instruction memory and program loader for the single-cycle core.
//   A program is streamed in over a valid/ready load port while the core is held
//   in reset. After the last word arrives the core is released, and instructions
//   are served combinationally from the core's pc. Any fetch fault or a core error
//   halts the core until the next reset.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   yukle_gecerli     load word valid
//   yukle_veri        load word
//   yukle_son         last-word marker, qualified by a transfer
//   yukle_hazir       loader can accept a word
//   pc                fetch byte address from the core
//   hata_cekirdek     error flag from the core
//   komut             instruction to the core (NOP when nothing valid to serve)
//   cekirdek_reset    active-high reset to the core
//   hata              sticky fault flag
//   durum             00 YUKLE, 01 CALIS, 10 DUR
//   yuklenen          number of words loaded
module komut_yukleyici #(
  parameter int          DERINLIK  = 256,
  parameter logic [31:0] BASLANGIC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        yukle_gecerli,
  input  logic [31:0]                 yukle_veri,
  input  logic                        yukle_son,
  output logic                        yukle_hazir,
  input  logic [31:0]                 pc,
  input  logic                        hata_cekirdek,
  output logic [31:0]                 komut,
  output logic                        cekirdek_reset,
  output logic                        hata,
  output logic [1:0]                  durum,
  output logic [$clog2(DERINLIK):0]   yuklenen
);

  localparam int          AW       = $clog2(DERINLIK);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [AW:0] DOLU     = (AW+1)'(DERINLIK);
  localparam logic [AW:0] SON_YUVA = (AW+1)'(DERINLIK - 1);
  localparam logic [29:0] IDX_SINIR = 30'(DERINLIK);

  typedef enum logic [1:0] {
    YUKLE = 2'b00,
    CALIS = 2'b01,
    DUR   = 2'b10
  } durum_t;

  durum_t      durum_q, durum_d;
  logic        hata_q, hata_d;
  // Word counter doubles as the write pointer; the extra bit lets it reach DERINLIK.
  logic [AW:0] sayac_q, sayac_d;

  logic [31:0] mem [DERINLIK];

  logic        aktarim;
  logic        hizasiz;
  logic        aralik_disi;
  logic        yuklu;
  logic        ariza;
  logic [29:0] idx;

  // Wrap-around subtraction: addresses below BASLANGIC land far out of range.
  assign idx         = 30'((pc - BASLANGIC) >> 2);
  assign hizasiz     = (pc[1:0] != 2'b00);
  assign aralik_disi = (idx >= IDX_SINIR);
  // In range but beyond the loaded program: serve NOP without faulting, which
  // also hides stale words left over from an earlier load.
  assign yuklu       = (idx < 30'(sayac_q));
  assign ariza       = hizasiz | aralik_disi;

  assign yukle_hazir    = (durum_q == YUKLE) && (sayac_q < DOLU);
  assign aktarim        = yukle_gecerli & yukle_hazir;
  assign cekirdek_reset = reset | (durum_q != CALIS);
  assign hata           = hata_q;
  assign durum          = durum_q;
  assign yuklenen       = sayac_q;

  always_comb begin
    komut = NOP;
    if (!reset && durum_q == CALIS && !ariza && yuklu) begin
      komut = mem[idx[AW-1:0]];
    end
  end

  always_comb begin
    durum_d = durum_q;
    hata_d  = hata_q;
    sayac_d = sayac_q;
    case (durum_q)
      YUKLE: begin
        if (aktarim) begin
          sayac_d = sayac_q + (AW+1)'(1);
          // Filling the last slot ends the load even without yukle_son.
          if (yukle_son || sayac_q == SON_YUVA) begin
            durum_d = CALIS;
          end
        end
      end
      CALIS: begin
        if (ariza || hata_cekirdek) begin
          durum_d = DUR;
          hata_d  = 1'b1;
        end
      end
      DUR: begin
      end
      default: begin
        durum_d = DUR;
        hata_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      durum_q <= YUKLE;
      hata_q  <= 1'b0;
      sayac_q <= '0;
    end else begin
      durum_q <= durum_d;
      hata_q  <= hata_d;
      sayac_q <= sayac_d;
    end
  end

  // Storage is never cleared; a transfer coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (aktarim && !reset) begin
      mem[sayac_q[AW-1:0]] <= yukle_veri;
    end
  end

endmodule

// File: tb/tb_komut_yukleyici.sv
module tb_komut_yukleyici;

  localparam int          D   = 4;
  localparam logic [31:0] B   = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        yukle_gecerli = 1'b0;
  logic [31:0] yukle_veri = '0;
  logic        yukle_son = 1'b0;
  logic        yukle_hazir;
  logic [31:0] pc = '0;
  logic        hata_cekirdek = 1'b0;
  logic [31:0] komut;
  logic        cekirdek_reset;
  logic        hata;
  logic [1:0]  durum;
  logic [2:0]  yuklenen;

  int n_vec = 0;
  int n_err = 0;

  komut_yukleyici #(.DERINLIK(D), .BASLANGIC(B)) dut (
    .clk(clk), .reset(reset), .yukle_gecerli(yukle_gecerli), .yukle_veri(yukle_veri),
    .yukle_son(yukle_son), .yukle_hazir(yukle_hazir), .pc(pc), .hata_cekirdek(hata_cekirdek),
    .komut(komut), .cekirdek_reset(cekirdek_reset), .hata(hata), .durum(durum),
    .yuklenen(yuklenen)
  );

  always #5 clk = ~clk;

  wire [39:0] obs = {durum, hata, cekirdek_reset, yukle_hazir, yuklenen, komut};

  // Reference model: the loaded program as a plain array plus a word count.
  logic [1:0]  m_state = 2'd0;  // 0 loading, 1 running, 2 halted
  logic        m_hata = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_mem [D];

  function automatic bit model_fault();
    logic [31:0] off;
    off = pc - B;
    return (pc % 4 != 0) || ((off / 4) >= D);
  endfunction

  function automatic logic [31:0] exp_komut();
    logic [31:0] off;
    int w;
    off = pc - B;
    if (reset || m_state != 2'd1 || model_fault()) return NOP;
    w = int'(off / 4);
    if (w >= m_cnt) return NOP;
    return m_mem[w];
  endfunction

  function automatic logic [39:0] exp_vec();
    logic crst, hz;
    crst = reset || (m_state != 2'd1);
    hz   = (m_state == 2'd0) && (m_cnt < D);
    return {m_state, m_hata, crst, hz, 3'(m_cnt), exp_komut()};
  endfunction

  task automatic tick();
    if (reset) begin
      m_state = 2'd0; m_cnt = 0; m_hata = 1'b0;
    end else begin
      case (m_state)
        2'd0: if (yukle_gecerli && m_cnt < D) begin
          m_mem[m_cnt] = yukle_veri;
          m_cnt++;
          if (yukle_son || m_cnt == D) m_state = 2'd1;
        end
        2'd1: if (model_fault() || hata_cekirdek) begin
          m_state = 2'd2; m_hata = 1'b1;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; yukle_gecerli = 1'b0; yukle_son = 1'b0; hata_cekirdek = 1'b0; pc = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input logic son);
    yukle_gecerli = 1'b1; yukle_veri = w; yukle_son = son;
    tick();
    yukle_gecerli = 1'b0; yukle_son = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (obs !== {2'b00, 1'b0, 1'b1, 1'b1, 3'd0, NOP}) begin
      n_err++; $display("FAIL reset_state got=%h want=%h", obs, {2'b00, 1'b0, 1'b1, 1'b1, 3'd0, NOP});
    end
  endtask

  task automatic test_basic_load();
    logic [31:0] prog [3];
    prog[0] = 32'h0050_0093; prog[1] = 32'h0030_0113; prog[2] = 32'h0020_81B3;
    do_reset();
    for (int i = 0; i < 3; i++) push(prog[i], i == 2);
    n_vec++;
    if ({durum, cekirdek_reset, yuklenen} !== {2'b01, 1'b0, 3'd3}) begin
      n_err++; $display("FAIL basic_release got=%b want=%b", {durum, cekirdek_reset, yuklenen}, {2'b01, 1'b0, 3'd3});
    end
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4); #1;
      n_vec++;
      if (komut !== prog[i]) begin
        n_err++; $display("FAIL basic_fetch pc=%h got=%h want=%h", pc, komut, prog[i]);
      end
    end
    pc = 32'd12; #1;
    n_vec++;
    if ({komut, hata} !== {NOP, 1'b0}) begin
      n_err++; $display("FAIL basic_unloaded got=%h/%b want=%h/0", komut, hata, NOP);
    end
    tick();
    n_vec++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL basic_unloaded_next got=%h want=%h", obs, exp_vec());
    end
    pc = '0;
  endtask

  task automatic test_backpressure();
    int words;
    do_reset();
    words = 0;
    for (int i = 0; i < 8; i++) begin
      yukle_gecerli = (i % 2 == 0);
      yukle_veri = 32'hA000_0000 + 32'(i);
      yukle_son = (i == 5);
      if (i % 2 == 0) words++;
      tick();
      n_vec++;
      if (yuklenen !== 3'(words)) begin
        n_err++; $display("FAIL gap_count step=%0d got=%0d want=%0d", i, yuklenen, words);
      end
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL gap_state step=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    yukle_gecerli = 1'b0; yukle_son = 1'b0;
    pc = 32'd12; #1;
    n_vec++;
    if (komut !== 32'hA000_0006) begin
      n_err++; $display("FAIL gap_last_word got=%h want=%h", komut, 32'hA000_0006);
    end
    pc = '0;
  endtask

  task automatic test_misaligned();
    do_reset();
    push(32'h1111_1111, 1'b0);
    push(32'h2222_2222, 1'b1);
    pc = 32'h0000_0006; #1;
    n_vec++;
    if (komut !== NOP) begin
      n_err++; $display("FAIL misaligned_komut got=%h want=%h", komut, NOP);
    end
    tick();
    pc = '0;
    for (int i = 0; i < 11; i++) begin
      #1;
      n_vec++;
      if ({durum, hata, cekirdek_reset, komut} !== {2'b10, 1'b1, 1'b1, NOP}) begin
        n_err++; $display("FAIL misaligned_halt cycle=%0d got=%h want=%h", i,
                          {durum, hata, cekirdek_reset, komut}, {2'b10, 1'b1, 1'b1, NOP});
      end
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++;
    if ({durum, hata} !== {2'b00, 1'b0}) begin
      n_err++; $display("FAIL misaligned_clear got=%b want=000", {durum, hata});
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < D; i++) push(32'hB000_0000 + 32'(i), 1'b0);
    n_vec++;
    if ({durum, yukle_hazir, yuklenen} !== {2'b01, 1'b0, 3'd4}) begin
      n_err++; $display("FAIL fill_state got=%b want=%b", {durum, yukle_hazir, yuklenen}, {2'b01, 1'b0, 3'd4});
    end
    pc = 32'd16; #1;
    n_vec++;
    if (komut !== NOP) begin
      n_err++; $display("FAIL fill_oor_komut got=%h want=%h", komut, NOP);
    end
    tick();
    n_vec++;
    if ({durum, hata} !== {2'b10, 1'b1}) begin
      n_err++; $display("FAIL fill_oor_halt got=%b want=101", {durum, hata});
    end
    do_reset();
    for (int i = 0; i < D; i++) push(32'hC000_0000 + 32'(i), 1'b0);
    pc = 32'd12; #1;
    n_vec++;
    if (komut !== 32'hC000_0003) begin
      n_err++; $display("FAIL fill_top_word got=%h want=%h", komut, 32'hC000_0003);
    end
    pc = 32'hFFFF_FFFC; tick();
    n_vec++;
    if ({durum, hata, cekirdek_reset} !== {2'b10, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL fill_wrap_halt got=%b want=1011", {durum, hata, cekirdek_reset});
    end
    pc = '0;
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    push(32'hD000_0000, 1'b0);
    push(32'hD000_0001, 1'b0);
    reset = 1'b1; yukle_gecerli = 1'b1; yukle_veri = 32'hD000_0002;
    tick();
    reset = 1'b0; yukle_gecerli = 1'b0;
    n_vec++;
    if ({yuklenen, yukle_hazir, cekirdek_reset, durum} !== {3'd0, 1'b1, 1'b1, 2'b00}) begin
      n_err++; $display("FAIL midreset_state got=%b want=%b",
                        {yuklenen, yukle_hazir, cekirdek_reset, durum}, {3'd0, 1'b1, 1'b1, 2'b00});
    end
    push(32'hE000_0000, 1'b1);
    pc = 32'd4; #1;
    n_vec++;
    if (komut !== NOP) begin
      n_err++; $display("FAIL midreset_stale got=%h want=%h", komut, NOP);
    end
    pc = 32'd0; #1;
    n_vec++;
    if (komut !== 32'hE000_0000) begin
      n_err++; $display("FAIL midreset_reload got=%h want=%h", komut, 32'hE000_0000);
    end
  endtask

  task automatic test_core_error();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'hF000_0000 + 32'(i), i == 2);
    hata_cekirdek = 1'b1; tick(); hata_cekirdek = 1'b0;
    n_vec++;
    if ({durum, hata, cekirdek_reset, komut} !== {2'b10, 1'b1, 1'b1, NOP}) begin
      n_err++; $display("FAIL core_err_halt got=%h want=%h", {durum, hata, cekirdek_reset, komut},
                        {2'b10, 1'b1, 1'b1, NOP});
    end
    yukle_gecerli = 1'b1; yukle_veri = 32'h1234_5678; yukle_son = 1'b1; #1;
    n_vec++;
    if (yukle_hazir !== 1'b0) begin
      n_err++; $display("FAIL core_err_hazir got=%b want=0", yukle_hazir);
    end
    tick();
    yukle_gecerli = 1'b0; yukle_son = 1'b0;
    n_vec++;
    if ({yuklenen, durum} !== {3'd3, 2'b10}) begin
      n_err++; $display("FAIL core_err_refuse got=%b want=%b", {yuklenen, durum}, {3'd3, 2'b10});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(0, 39) == 0);
      yukle_gecerli = $urandom_range(0, 1);
      yukle_veri    = $urandom;
      yukle_son     = ($urandom_range(0, 3) == 0);
      hata_cekirdek = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) pc = $urandom;
      else pc = B + 32'($urandom_range(0, D - 1) * 4);
      #1;
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random step=%0d pc=%h got=%h want=%h", i, pc, obs, exp_vec());
      end
      tick();
    end
    reset = 1'b0; yukle_gecerli = 1'b0; yukle_son = 1'b0; hata_cekirdek = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_misaligned();
    test_fill();
    test_reset_mid_load();
    test_core_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
